// File: rtl/manchester_rx.sv
// Oversampled Manchester receiver: preamble lock, "11" SFD, LSB-first word deserializer.
// Define MANCH_RX_ERRCNT_EN to add the 8-bit saturating err/ovr event counter port err_cnt.
module manchester_rx #(
  parameter int OVS      = 8,
  parameter int DW       = 8,
  parameter int PRE_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_in,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          locked,
  output logic          frame_end,
  output logic          err,
  output logic          ovr
`ifdef MANCH_RX_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  localparam int CW   = $clog2(2 * OVS) + 1;
  localparam int MAXB = (DW > PRE_BITS) ? DW : PRE_BITS;
  localparam int BCW  = $clog2(MAXB + 1);

  localparam logic [CW-1:0]  LO_C  = CW'(OVS - OVS / 4);
  localparam logic [CW-1:0]  HI_C  = CW'(OVS + OVS / 4);
  localparam logic [BCW-1:0] DW_C  = BCW'(DW);
  localparam logic [BCW-1:0] PRE_C = BCW'(PRE_BITS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] SFD  = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  logic          sync1_q, sync2_q, line_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BCW-1:0] bitCnt_q, bitCnt_d;
  logic          prevBit_q, prevBit_d;
  logic [DW-1:0] sr_q, sr_d;
  logic          locked_q, locked_d;
  logic          frameEnd_q, frameEnd_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;

  logic          edgeDet, edgeBit, timeout, inWindow, accept, wordDone;
  logic [CW-1:0] phase;
  logic [BCW-1:0] bitInc;
  logic [DW-1:0] wordVal;

  // phase is the number of clk since the last accepted edge, so a nominal bit reads OVS
  assign edgeDet  = sync2_q ^ line_q;
  assign edgeBit  = sync2_q;
  assign phase    = cnt_q + CW'(1);
  assign bitInc   = bitCnt_q + BCW'(1);
  assign timeout  = (state_q != IDLE) && (phase > HI_C);
  assign inWindow = (phase >= LO_C) && (phase <= HI_C);
  assign accept   = edgeDet && !timeout && ((state_q == IDLE) || inWindow);
  assign wordVal  = {edgeBit, sr_q[DW-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == IDLE) ? '0 : phase;
    bitCnt_d   = bitCnt_q;
    prevBit_d  = prevBit_q;
    sr_d       = sr_q;
    locked_d   = locked_q;
    frameEnd_d = 1'b0;
    err_d      = 1'b0;
    wordDone   = 1'b0;
    if (accept) cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (edgeDet) begin
          state_d   = PRE;
          bitCnt_d  = BCW'(1);
          prevBit_d = edgeBit;
        end
      end
      PRE: begin
        if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          bitCnt_d = '0;
        end else if (accept) begin
          if (edgeBit == prevBit_q) begin
            state_d  = IDLE;
            bitCnt_d = '0;
          end else begin
            prevBit_d = edgeBit;
            if (bitInc >= PRE_C) begin
              state_d  = SFD;
              locked_d = 1'b1;
              bitCnt_d = '0;
            end else begin
              bitCnt_d = bitInc;
            end
          end
        end
      end
      SFD: begin
        if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end else if (accept) begin
          prevBit_d = edgeBit;
          // two equal bits end the alternating run: "11" is the SFD, "00" is a violation
          if (edgeBit == prevBit_q) begin
            if (edgeBit) begin
              state_d  = DATA;
              bitCnt_d = '0;
            end else begin
              state_d  = IDLE;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        if (timeout) begin
          state_d    = IDLE;
          cnt_d      = '0;
          locked_d   = 1'b0;
          bitCnt_d   = '0;
          frameEnd_d = (bitCnt_q == '0);
          err_d      = (bitCnt_q != '0);
        end else if (accept) begin
          sr_d = wordVal;
          if (bitInc == DW_C) begin
            wordDone = 1'b1;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitInc;
          end
        end
      end
    endcase
  end

  // a completing word may replace the held one only when it is being taken this cycle
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (wordDone) begin
      if (!valid_q || dout_ready) begin
        dout_d  = wordVal;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      line_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitCnt_q   <= '0;
      prevBit_q  <= 1'b0;
      sr_q       <= '0;
      locked_q   <= 1'b0;
      frameEnd_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= d_in;
      sync2_q    <= sync1_q;
      line_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitCnt_q   <= bitCnt_d;
      prevBit_q  <= prevBit_d;
      sr_q       <= sr_d;
      locked_q   <= locked_d;
      frameEnd_q <= frameEnd_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

`ifdef MANCH_RX_ERRCNT_EN
  logic [7:0] errCnt_q, errCnt_d;
  logic [8:0] errSum;

  assign errSum   = {1'b0, errCnt_q} + {8'd0, err_d} + {8'd0, ovr_d};
  assign errCnt_d = errSum[8] ? 8'hFF : errSum[7:0];

  always_ff @(posedge clk) begin
    if (rst) errCnt_q <= '0;
    else     errCnt_q <= errCnt_d;
  end

  assign err_cnt = errCnt_q;
`endif

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign locked     = locked_q;
  assign frame_end  = frameEnd_q;
  assign err        = err_q;
  assign ovr        = ovr_q;

endmodule
